// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin arbiter and sequencer that shares a single
//               combinational ALU among NUM_REQ requesters. One requester is
//               granted per cycle; its fields drive the ALU, and the ALU
//               result is captured into a one-entry response register that is
//               tagged with the requester index.
// Ports       : clk_i / rst_ni         - clock, asynchronous active-low reset
//               req_valid_i/req_ready_o - per-requester handshake (ready is
//                                        one-hot or zero)
//               req_operation_i        - packed 6-bit op codes, req i at [6i+:6]
//               req_operand_A_i/B_i    - packed operands, req i at [DW*i+:DW]
//               alu_operation_o/A_o/B_o- drive to the shared ALU
//               alu_result_i           - same-cycle result from the ALU
//               resp_valid_o/ready_i   - response handshake
//               resp_data_o/resp_id_o  - captured result and requester tag
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2,
    parameter int ID_WIDTH   = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic [6*NUM_REQ-1:0]         req_operation_i,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_operand_A_i,
    input  logic [DATA_WIDTH*NUM_REQ-1:0] req_operand_B_i,
    output logic [5:0]                   alu_operation_o,
    output logic [DATA_WIDTH-1:0]        alu_operand_A_o,
    output logic [DATA_WIDTH-1:0]        alu_operand_B_o,
    input  logic [DATA_WIDTH-1:0]        alu_result_i,
    output logic                         resp_valid_o,
    input  logic                         resp_ready_i,
    output logic [DATA_WIDTH-1:0]        resp_data_o,
    output logic [ID_WIDTH-1:0]          resp_id_o
);

    localparam int                VALID_PAD_W = 2 ** ID_WIDTH;
    localparam logic [ID_WIDTH:0] NUM_REQ_W   = (ID_WIDTH + 1)'(NUM_REQ);
    localparam logic [ID_WIDTH-1:0] LAST_IDX  = ID_WIDTH'(NUM_REQ - 1);

    // State
    logic [ID_WIDTH-1:0]   rr_ptr_q,     rr_ptr_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_data_q,  resp_data_d;
    logic [ID_WIDTH-1:0]   resp_id_q,    resp_id_d;

    // Grant datapath
    logic                   can_accept;
    logic                   grant_valid;
    logic [ID_WIDTH-1:0]    grant_idx;
    logic [ID_WIDTH:0]      idx_sum;
    logic [VALID_PAD_W-1:0] valid_pad;

    // Padding to the full tag range lets the scan index the vector with an
    // exact-width index; the padded bits are zero so they never win.
    assign valid_pad = VALID_PAD_W'(req_valid_i);

    // Holding reset also blocks acceptance so req_ready stays low in reset.
    assign can_accept = rst_ni && (!resp_valid_q || resp_ready_i);

    // Round-robin scan starting at rr_ptr_q, wrapping at NUM_REQ-1.
    // rr_ptr_q < NUM_REQ, so a single conditional subtract handles the wrap.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx_sum     = '0;
        if (can_accept) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx_sum = {1'b0, rr_ptr_q} + (ID_WIDTH + 1)'(k);
                if (idx_sum >= NUM_REQ_W) begin
                    idx_sum = idx_sum - NUM_REQ_W;
                end
                // The range guard keeps out-of-range indices from ever being
                // granted even if the pointer were somehow corrupted.
                if (!grant_valid && (idx_sum < NUM_REQ_W) &&
                    valid_pad[idx_sum[ID_WIDTH-1:0]]) begin
                    grant_valid = 1'b1;
                    grant_idx   = idx_sum[ID_WIDTH-1:0];
                end
            end
        end
    end

    // One-hot ready and ALU operand mux. No grant drives zeros (ADD of 0s).
    always_comb begin
        req_ready_o     = '0;
        alu_operation_o = '0;
        alu_operand_A_o = '0;
        alu_operand_B_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_valid && (grant_idx == ID_WIDTH'(i))) begin
                req_ready_o[i]  = 1'b1;
                alu_operation_o = req_operation_i[6*i +: 6];
                alu_operand_A_o = req_operand_A_i[DATA_WIDTH*i +: DATA_WIDTH];
                alu_operand_B_o = req_operand_B_i[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    // Next-state: a grant always implies the handshake fired, and it also
    // covers the drain-and-reload case because can_accept included resp_ready.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        if (grant_valid) begin
            resp_data_d  = alu_result_i;
            resp_id_d    = grant_idx;
            resp_valid_d = 1'b1;
            rr_ptr_d     = (grant_idx == LAST_IDX) ? '0 : grant_idx + ID_WIDTH'(1);
        end else if (resp_valid_q && resp_ready_i) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_data_o  = resp_data_q;
    assign resp_id_o    = resp_id_q;

endmodule
`default_nettype wire
